branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, number of direct-mapped BTB entries (power of two, 4..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have port if_pc  input  32  fetch-stage PC being looked up.
REQ-005 SHALL have port pred_taken  output  1  fetch prediction: redirect to pred_target.
REQ-006 SHALL have port pred_target  output  32  predicted next PC.
REQ-007 SHALL have port ex_valid  input  1  EX stage holds a live instruction this cycle.
REQ-008 SHALL have port ex_op  input  4  EX branch op: bit3=branch/jump; [2:0]: 010 JAL/JALR, 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-009 SHALL have port ex_pc  input  32  PC of the EX instruction.
REQ-010 SHALL have port ex_taken  input  1  resolved branch outcome from the EX branch decision.
REQ-011 SHALL have port ex_target  input  32  resolved target address.
REQ-012 SHALL have port ex_pred_taken  input  1  prediction carried down the pipeline with the instruction.
REQ-013 SHALL have port ex_pred_target  input  32  predicted target carried with the instruction.
REQ-014 SHALL have port mispredict  output  1  flush IF/ID and redirect fetch.
REQ-015 SHALL have port redirect_pc  output  32  correct next PC when mispredict=1.
REQ-016 SHALL have port branch_count  output  16  resolved branch/jump count.
REQ-017 SHALL have port mispredict_count  output  16  mispredict count.

Function
REQ-018 SHALL index with pc[IDX+1:2], IDX=log2(ENTRIES); tag = pc[31:IDX+2]; entry = valid, tag, 32-bit target, 2-bit counter.
REQ-019 SHALL compute lookup combinationally: hit = valid & tag match; pred_taken = hit & ctr[1]; pred_target = pred_taken ? entry target : if_pc+4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
REQ-020 A resolve event SHALL be ex_valid=1 and ex_op[3]=1; otherwise no update, no count, mispredict=0.
REQ-021 On resolve, mispredict SHALL be combinationally 1 iff ex_taken!=ex_pred_taken, or both 1 and ex_target!=ex_pred_target.
REQ-022 redirect_pc SHALL be ex_taken ? ex_target : ex_pc+4 when mispredict=1, else 0.
REQ-023 On resolve at rising edge, hit entry SHALL: counter saturating +1 if taken (max 11), -1 if not (min 00); target written with ex_target if taken.
REQ-024 On resolve miss with ex_taken=1, SHALL allocate (overwrite): valid=1, tag, target=ex_target, counter=10.
REQ-025 On resolve miss with ex_taken=0, table SHALL be unchanged.
REQ-026 ex_op[2:0]=010 SHALL be treated as taken for table update regardless of ex_taken, counter forced to 11.
REQ-027 Lookup and update to same index in one cycle SHALL return pre-update state; new state visible next cycle.
REQ-028 branch_count SHALL increment per resolve; mispredict_count per mispredict; both saturate at 0xFFFF.
REQ-029 Unused op codes (bit3=1, [2:0]=011) SHALL count as resolve, use ex_taken, follow REQ-023..025.

Reset
REQ-030 While reset=1: all valid=0, counters=01, targets=0, branch_count=0, mispredict_count=0, mispredict=0, redirect_pc=0, pred_taken=0, pred_target=if_pc+4.
REQ-031 Reset asserted mid-operation SHALL discard any in-progress update; first update accepted on first rising edge after deassertion.

Verification
REQ-032 Reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104, counts 0.
REQ-033 Resolve BEQ ex_pc=0x100, taken, target 0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80; next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80; counts 1/1.
REQ-034 Same entry resolved not-taken twice -> counter 10->01->00; if_pc=0x100 -> pred_taken=0, pred_target=0x104; second resolve with pred_taken=1 raises mispredict, redirect_pc=0x104.
REQ-035 Alias: 0x100 allocated, then taken branch at 0x120 (ENTRIES=8) -> overwritten; if_pc=0x100 misses, pred_target=0x104.
REQ-036 JAL ex_pc=0x200, target 0x400, correctly predicted -> mispredict=0, counter=11, branch_count+1 only; ex_op=0100 -> no update, no count.
REQ-037 Drive 65540 mispredicting resolves -> both counters hold 0xFFFF; reset mid-cycle -> all zero asynchronously.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, EX-stage resolve/update,
// mispredict detection and saturating branch/mispredict statistics.
module branch_predictor #(
    parameter int ENTRIES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [15:0] branch_count,
    output logic [15:0] mispredict_count
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = 30 - IDX;

    logic          valid_q [ENTRIES];
    logic [TW-1:0] tag_q   [ENTRIES];
    logic [31:0]   tgt_q   [ENTRIES];
    logic [1:0]    ctr_q   [ENTRIES];
    logic [15:0]   bcnt_q, bcnt_d;
    logic [15:0]   mcnt_q, mcnt_d;

    logic          unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    // Fetch lookup reads registered state only, so a same-cycle update is not visible.
    logic [IDX-1:0] lu_idx;
    logic           lu_hit;
    assign lu_idx      = if_pc[IDX+1:2];
    assign lu_hit      = valid_q[lu_idx] && (tag_q[lu_idx] == if_pc[31:IDX+2]);
    assign pred_taken  = lu_hit && ctr_q[lu_idx][1];
    assign pred_target = pred_taken ? tgt_q[lu_idx] : if_pc + 32'd4;

    logic           resolve;
    logic           is_jal;
    logic           upd_taken;
    logic [IDX-1:0] ex_idx;
    logic [TW-1:0]  ex_tag;
    logic           ex_hit;
    assign resolve   = ex_valid && ex_op[3];
    assign is_jal    = (ex_op[2:0] == 3'b010);
    assign upd_taken = ex_taken || is_jal;
    assign ex_idx    = ex_pc[IDX+1:2];
    assign ex_tag    = ex_pc[31:IDX+2];
    assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    assign mispredict  = !reset && resolve &&
                         ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = !mispredict ? 32'd0 :
                         ex_taken    ? ex_target : ex_pc + 32'd4;

    logic        upd_we;
    logic [31:0] tgt_d;
    logic [1:0]  ctr_d;

    always_comb begin
        upd_we = 1'b0;
        tgt_d  = tgt_q[ex_idx];
        ctr_d  = ctr_q[ex_idx];
        if (resolve) begin
            if (ex_hit) begin
                upd_we = 1'b1;
                if (is_jal)
                    ctr_d = 2'b11;
                else if (upd_taken)
                    ctr_d = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
                else
                    ctr_d = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
                if (upd_taken)
                    tgt_d = ex_target;
            end else if (upd_taken) begin
                // Allocation overwrites whatever aliased entry lived here.
                upd_we = 1'b1;
                tgt_d  = ex_target;
                ctr_d  = is_jal ? 2'b11 : 2'b10;
            end
        end
    end

    always_comb begin
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        if (resolve && bcnt_q != 16'hFFFF)
            bcnt_d = bcnt_q + 16'd1;
        if (mispredict && mcnt_q != 16'hFFFF)
            mcnt_d = mcnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= 32'd0;
                ctr_q[i]   <= 2'b01;
            end
            bcnt_q <= 16'd0;
            mcnt_q <= 16'd0;
        end else begin
            if (upd_we) begin
                valid_q[ex_idx] <= 1'b1;
                tag_q[ex_idx]   <= ex_tag;
                tgt_q[ex_idx]   <= tgt_d;
                ctr_q[ex_idx]   <= ctr_d;
            end
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign branch_count     = bcnt_q;
    assign mispredict_count = mcnt_q;
endmodule
